// File: rtl/proc_datapath.sv
// proc_datapath
//   Register-file datapath driven by the control FSM's strobes. Holds the
//   instruction register IR, general registers R0..R7, the ALU operand
//   register A, the ALU result register G and the Z/N/C flags. It also drives
//   the shared bus. IR is fed back to the control FSM as its instruction input.
//
// Ports
//   clock     in   1       rising-edge clock
//   Rest      in   1       asynchronous active-low reset, clears all state
//   DIN       in   DATA_W  instruction word from memory
//   IRin      in   1       IR <= DIN
//   Rin       in   8       Rin[7-k] writes bus into Rk (Rin[7]=R0 ... Rin[0]=R7)
//   sel       in   4       bus source: 0..7 Rk, 8 G, 9 imm, 10 mvt, else 0
//   Ain       in   1       A <= bus
//   Gin       in   1       G <= A +/- bus, flags updated
//   addsub    in   1       0: add, 1: subtract (only meaningful with Gin=1)
//   IR        out  DATA_W  instruction register
//   BusWires  out  DATA_W  current bus value (combinational from sel)
//   G         out  DATA_W  ALU result register
//   flag_z    out  1       result was zero at the last Gin
//   flag_n    out  1       result MSB at the last Gin
//   flag_c    out  1       carry out (add) / no-borrow (sub)
module proc_datapath #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 9
) (
  input  logic              clock,
  input  logic              Rest,
  input  logic [DATA_W-1:0] DIN,
  input  logic              IRin,
  input  logic [7:0]        Rin,
  input  logic [3:0]        sel,
  input  logic              Ain,
  input  logic              Gin,
  input  logic              addsub,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] BusWires,
  output logic [DATA_W-1:0] G,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  localparam int HALF_W = DATA_W / 2;

  logic [DATA_W-1:0] r [8];
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W:0]   alu_sum;

  // Subtraction is done as A + ~bus + 1 so the top bit of the widened sum is
  // the carry for add and the no-borrow indication for subtract.
  function automatic logic [DATA_W:0] alu_calc(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sub);
    logic [DATA_W-1:0] b_op;
    b_op = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
  endfunction

  // Bus source mux; unknown selects fall into the default and drive zero.
  always_comb begin
    BusWires = '0;
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: BusWires = r[sel[2:0]];
      4'd8:                   BusWires = G;
      4'd9:                   BusWires = {{(DATA_W-IMM_W){1'b0}}, IR[IMM_W-1:0]};
      4'd10:                  BusWires = {IR[HALF_W-1:0], {HALF_W{1'b0}}};
      default:                BusWires = '0;
    endcase
  end

  assign alu_sum = alu_calc(a_reg, BusWires, addsub);

  // Register stage: all loads sample the pre-edge bus, so self-reloads,
  // A/G overlap and IR/imm overlap all see old values.
  always_ff @(posedge clock or negedge Rest) begin
    if (!Rest) begin
      IR     <= '0;
      a_reg  <= '0;
      G      <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      for (int k = 0; k < 8; k++) r[k] <= '0;
    end else begin
      if (IRin) IR <= DIN;
      for (int k = 0; k < 8; k++) begin
        if (Rin[7-k]) r[k] <= BusWires;
      end
      if (Ain) a_reg <= BusWires;
      if (Gin) begin
        G      <= alu_sum[DATA_W-1:0];
        flag_c <= alu_sum[DATA_W];
        flag_z <= (alu_sum[DATA_W-1:0] == '0);
        flag_n <= alu_sum[DATA_W-1];
      end
    end
  end

endmodule
